torpedo_hit_detector: RTL and testbench

Frame-based collision responder for the torpedo units. It watches the per-pixel draw flags that the torpedo and asteroid sprite layers produce during active video and accumulates torpedo/asteroid overlaps over one frame. On each vsync it returns one-cycle kill pulses to the torpedos that hit, hit pulses to the asteroid units, and a BCD score update. It sits after the sprite chain, beside the VGA output stage, and closes the fire → fly → die loop from the receiving end.

---
 rtl/torpedo_hit_detector_if.sv | 32 +++
 rtl/torpedo_hit_detector.sv | 167 ++++++++++++++++
 tb/tb_torpedo_hit_detector.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/torpedo_hit_detector_if.sv
// Signal bundle between the sprite/video side and the torpedo hit detector.
// Flow control: there is no valid/ready back-pressure on this bus. pixel_valid
// qualifies each pixel sample, vsync marks a frame edge (one cycle per frame),
// and t_kill/ast_hit are single-cycle pulses that the receivers must take in
// the cycle they appear. fsm_state mirrors the detector's FSM for observation.
interface torpedo_hit_detector_if #(
  parameter int N_TORP       = 4,
  parameter int N_AST        = 8,
  parameter int SCORE_DIGITS = 4
);
  logic                      vsync;
  logic                      pixel_valid;
  logic [N_TORP-1:0]         t_fire;
  logic [N_TORP-1:0]         torpedo_draw;
  logic [N_AST-1:0]          asteroid_draw;
  logic                      clear_score;
  logic [N_TORP-1:0]         t_kill;
  logic [N_AST-1:0]          ast_hit;
  logic [4*SCORE_DIGITS-1:0] score;
  logic                      overrun;
  logic [1:0]                fsm_state;

  modport master (
    output vsync, pixel_valid, t_fire, torpedo_draw, asteroid_draw, clear_score,
    input  t_kill, ast_hit, score, overrun, fsm_state
  );

  modport slave (
    input  vsync, pixel_valid, t_fire, torpedo_draw, asteroid_draw, clear_score,
    output t_kill, ast_hit, score, overrun, fsm_state
  );
endinterface

// File: rtl/torpedo_hit_detector.sv
// Frame-based torpedo/asteroid collision responder. Overlaps are accumulated
// over a frame; each vsync snapshots the qualified hits, reports them as
// one-cycle pulses, then walks the asteroids adding one BCD point per hit.
module torpedo_hit_detector #(
  parameter int N_TORP       = 4,
  parameter int N_AST        = 8,
  parameter int MIN_OVERLAP  = 2,
  parameter int SCORE_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  torpedo_hit_detector_if.slave bus
);

  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int IDX_W = (N_AST > 1) ? $clog2(N_AST) : 1;
  localparam logic [3:0]       OVL_MAX   = 4'(MIN_OVERLAP);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_AST - 1);
  localparam logic [SW-1:0]    ALL_NINES = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    REPORT = 2'd1,
    SCORE  = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            inc;
  logic [N_TORP-1:0][N_AST-1:0]    pair_q;
  logic [N_TORP-1:0][3:0]          ovl_q;
  logic [N_TORP-1:0]               snap_t_q;
  logic [N_AST-1:0]                snap_a_q;
  logic [SW-1:0]                   score_q;
  logic                            overrun_q;

  logic [N_TORP-1:0][N_AST-1:0]    hit;
  logic [N_TORP-1:0]               torp_hit;
  logic [N_TORP-1:0]               qual;
  logic [N_AST-1:0]                snap_a_d;

  // Add one to a BCD value; carry ripples through every digit in one cycle.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < SCORE_DIGITS; k++) begin
      if (carry) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Per-pixel hit matrix, torpedo qualification and asteroid snapshot value.
  always_comb begin
    hit      = '0;
    torp_hit = '0;
    qual     = '0;
    snap_a_d = '0;
    for (int i = 0; i < N_TORP; i++) begin
      for (int j = 0; j < N_AST; j++) begin
        hit[i][j] = bus.pixel_valid & bus.t_fire[i] & bus.torpedo_draw[i] &
                    bus.asteroid_draw[j];
      end
      torp_hit[i] = |hit[i];
      qual[i]     = (ovl_q[i] == OVL_MAX);
      for (int j = 0; j < N_AST; j++) begin
        snap_a_d[j] = snap_a_d[j] | (pair_q[i][j] & qual[i]);
      end
    end
  end

  // Frame accumulation and snapshot; the vsync cycle's own pixel is dropped.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pair_q   <= '0;
      ovl_q    <= '0;
      snap_t_q <= '0;
      snap_a_q <= '0;
    end else if (bus.vsync) begin
      pair_q   <= '0;
      ovl_q    <= '0;
      snap_t_q <= qual;
      snap_a_q <= snap_a_d;
    end else begin
      pair_q <= pair_q | hit;
      for (int i = 0; i < N_TORP; i++) begin
        if (torp_hit[i] && (ovl_q[i] != OVL_MAX)) begin
          ovl_q[i] <= ovl_q[i] + 4'd1;
        end
      end
    end
  end

  // FSM state and scan index registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ACCUM;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: report for one cycle, then scan asteroids; vsync always restarts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inc     = 1'b0;
    case (state_q)
      ACCUM: begin
      end
      REPORT: begin
        state_d = SCORE;
        idx_d   = '0;
      end
      SCORE: begin
        inc = snap_a_q[idx_q];
        if (idx_q == IDX_LAST) begin
          state_d = ACCUM;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ACCUM;
    endcase
    // A new frame edge abandons whatever scoring is left of the old snapshot.
    if (bus.vsync) begin
      state_d = REPORT;
      idx_d   = '0;
      inc     = 1'b0;
    end
  end

  // Score counter (saturating BCD) and sticky overrun flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q   <= '0;
      overrun_q <= 1'b0;
    end else if (bus.clear_score) begin
      score_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (inc && (score_q != ALL_NINES)) begin
        score_q <= bcd_inc(score_q);
      end
      if (bus.vsync && (state_q != ACCUM)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.t_kill    = (state_q == REPORT) ? snap_t_q : '0;
  assign bus.ast_hit   = (state_q == REPORT) ? snap_a_q : '0;
  assign bus.score     = score_q;
  assign bus.overrun   = overrun_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_torpedo_hit_detector.sv
// Bench for torpedo_hit_detector: table-driven frames, random frames against
// a frame-level reference model, and hand sequences for BCD carry,
// saturation, clear priority, overrun and asynchronous reset.
module tb_torpedo_hit_detector;

  localparam int NT        = 4;
  localparam int NA        = 8;
  localparam int MINO      = 2;
  localparam int SD        = 4;
  localparam int SW        = 4 * SD;
  localparam int MAX_SCORE = 9999;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  torpedo_hit_detector_if #(.N_TORP(NT), .N_AST(NA), .SCORE_DIGITS(SD)) bus ();

  torpedo_hit_detector #(
    .N_TORP(NT), .N_AST(NA), .MIN_OVERLAP(MINO), .SCORE_DIGITS(SD)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int                 m_cnt[NT];
  logic [NA-1:0]      m_pair[NT];
  int                 exp_score = 0;
  logic [NT+NA-1:0]   exp_q[$];

  typedef struct {
    string         name;
    logic          pv;
    logic [NT-1:0] fire;
    logic [NT-1:0] td;
    logic [NA-1:0] ad;
    int            npix;
    logic [NT-1:0] kill;
    logic [NA-1:0] hit;
  } tvec_t;

  tvec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] to_bcd(input int v);
    logic [SW-1:0] r;
    int            t;
    r = '0;
    t = v;
    for (int k = 0; k < SD; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      m_cnt[i]  = 0;
      m_pair[i] = '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic pv, input logic [NT-1:0] fire, input logic [NT-1:0] td,
                            input logic [NA-1:0] ad, input logic vs, input logic clr);
    bus.pixel_valid   = pv;
    bus.t_fire        = fire;
    bus.torpedo_draw  = td;
    bus.asteroid_draw = ad;
    bus.vsync         = vs;
    bus.clear_score   = clr;
  endtask

  task automatic idle(input int n);
    set_inputs(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  // One active pixel; the model counts pixels where each torpedo hits anything.
  task automatic pix(input logic pv, input logic [NT-1:0] fire, input logic [NT-1:0] td,
                     input logic [NA-1:0] ad);
    set_inputs(pv, fire, td, ad, 1'b0, 1'b0);
    for (int i = 0; i < NT; i++) begin
      if (pv && fire[i] && td[i] && (ad != '0)) begin
        m_cnt[i]++;
        m_pair[i] |= ad;
      end
    end
    step();
  endtask

  // Frame edge; drives a full-hit pixel that must be ignored. Returns in T+1.
  task automatic vsync_cycle();
    logic [NT-1:0] k;
    logic [NA-1:0] h;
    int            s;
    k = '0;
    h = '0;
    for (int i = 0; i < NT; i++) begin
      if (m_cnt[i] >= MINO) begin
        k[i] = 1'b1;
        h    = h | m_pair[i];
      end
    end
    exp_q.push_back({k, h});
    s = exp_score + $countones(h);
    exp_score = (s > MAX_SCORE) ? MAX_SCORE : s;
    model_clear();
    set_inputs(1'b1, '1, '1, '1, 1'b1, 1'b0);
    step();
    set_inputs(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic use_tbl,
                             input logic [NT-1:0] tk, input logic [NA-1:0] ah);
    logic [NT+NA-1:0] e;
    vsync_cycle();
    e = exp_q.pop_front();
    if (!use_tbl) begin
      tk = e[NA +: NT];
      ah = e[NA-1:0];
    end
    check($sformatf("%s t_kill", tag), 32'(bus.t_kill), 32'(tk));
    check($sformatf("%s ast_hit", tag), 32'(bus.ast_hit), 32'(ah));
    idle(1);
    check($sformatf("%s pulse_end", tag), 32'({bus.t_kill, bus.ast_hit}), 32'd0);
    idle(NA);
    check($sformatf("%s score", tag), 32'(bus.score), 32'(to_bcd(exp_score)));
  endtask

  task automatic quiet_frame(input logic [NA-1:0] mask);
    logic [NT+NA-1:0] e;
    pix(1'b1, 4'b0001, 4'b0001, mask);
    pix(1'b1, 4'b0001, 4'b0001, mask);
    vsync_cycle();
    e = exp_q.pop_front();
    idle(NA + 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{"single",      1'b1, 4'b0001, 4'b0001, 8'h08, 3, 4'b0001, 8'h08};
    tbl[1] = '{"thresh1",     1'b1, 4'b0001, 4'b0001, 8'h08, 1, 4'b0000, 8'h00};
    tbl[2] = '{"thresh2",     1'b1, 4'b0001, 4'b0001, 8'h08, 2, 4'b0001, 8'h08};
    tbl[3] = '{"multi",       1'b1, 4'b0110, 4'b0110, 8'h81, 2, 4'b0110, 8'h81};
    tbl[4] = '{"gate_fire",   1'b1, 4'b0000, 4'b0100, 8'h02, 4, 4'b0000, 8'h00};
    tbl[5] = '{"gate_pv",     1'b0, 4'b0100, 4'b0100, 8'h02, 4, 4'b0000, 8'h00};
    tbl[6] = '{"all",         1'b1, 4'b1111, 4'b1111, 8'hff, 2, 4'b1111, 8'hff};
    tbl[7] = '{"no_asteroid", 1'b1, 4'b1111, 4'b1111, 8'h00, 5, 4'b0000, 8'h00};

    model_clear();
    set_inputs(1'b0, '0, '0, '0, 1'b0, 1'b0);
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset score",   32'(bus.score), 32'd0);
    check("reset overrun", 32'(bus.overrun), 32'd0);
    check("reset pulses",  32'({bus.t_kill, bus.ast_hit}), 32'd0);
    check("reset state",   32'(bus.fsm_state), 32'd0);
    resetN = 1'b1;
    idle(2);

    // Table-driven frames.
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < tbl[t].npix; p++) pix(tbl[t].pv, tbl[t].fire, tbl[t].td, tbl[t].ad);
      check_frame(tbl[t].name, 1'b1, tbl[t].kill, tbl[t].hit);
    end

    // Random frames against the model.
    for (int f = 0; f < 24; f++) begin
      int np;
      np = $urandom_range(0, 6);
      for (int p = 0; p < np; p++) begin
        pix(($urandom_range(0, 7) != 0), NT'($urandom), NT'($urandom & $urandom),
            NA'($urandom & $urandom & $urandom));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      check_frame($sformatf("rand%0d", f), 1'b0, '0, '0);
    end

    // Plain clear, then overrun: second vsync three cycles after the first.
    set_inputs(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step();
    idle(1);
    exp_score = 0;
    check("clear score", 32'(bus.score), 32'd0);
    pix(1'b1, 4'b0001, 4'b0001, 8'h21);
    pix(1'b1, 4'b0001, 4'b0001, 8'h21);
    vsync_cycle();
    void'(exp_q.pop_front());
    check("ovr first t_kill",  32'(bus.t_kill), 32'h1);
    check("ovr first ast_hit", 32'(bus.ast_hit), 32'h21);
    pix(1'b1, 4'b0001, 4'b0001, 8'h04);
    pix(1'b1, 4'b0001, 4'b0001, 8'h04);
    vsync_cycle();
    void'(exp_q.pop_front());
    check("ovr second t_kill",  32'(bus.t_kill), 32'h1);
    check("ovr second ast_hit", 32'(bus.ast_hit), 32'h04);
    check("ovr flag",           32'(bus.overrun), 32'd1);
    idle(NA + 1);
    exp_score = 2;
    check("ovr truncated score", 32'(bus.score), 32'h0002);
    check("ovr sticky",          32'(bus.overrun), 32'd1);

    // BCD carry and saturation.
    set_inputs(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step();
    idle(1);
    exp_score = 0;
    check("clear overrun", 32'(bus.overrun), 32'd0);
    repeat (12) quiet_frame(8'hff);
    quiet_frame(8'h07);
    check("score 0099", 32'(bus.score), 32'h0099);
    pix(1'b1, 4'b0001, 4'b0001, 8'h01);
    pix(1'b1, 4'b0001, 4'b0001, 8'h01);
    check_frame("carry", 1'b0, '0, '0);
    check("score 0100", 32'(bus.score), 32'h0100);
    repeat (1237) quiet_frame(8'hff);
    quiet_frame(8'h07);
    check("score 9999", 32'(bus.score), 32'h9999);
    pix(1'b1, 4'b0001, 4'b0001, 8'h01);
    pix(1'b1, 4'b0001, 4'b0001, 8'h01);
    check_frame("saturate", 1'b0, '0, '0);
    check("score stays 9999", 32'(bus.score), 32'h9999);

    // clear_score in the same cycle as the asteroid-0 increment (T+2).
    pix(1'b1, 4'b0001, 4'b0001, 8'h01);
    pix(1'b1, 4'b0001, 4'b0001, 8'h01);
    vsync_cycle();
    void'(exp_q.pop_front());
    step();
    set_inputs(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step();
    set_inputs(1'b0, '0, '0, '0, 1'b0, 1'b0);
    exp_score = 0;
    check("clear beats inc", 32'(bus.score), 32'd0);
    idle(NA - 1);
    check("clear beats inc end", 32'(bus.score), 32'd0);

    // Asynchronous reset in the middle of scoring.
    pix(1'b1, 4'b0001, 4'b0001, 8'hff);
    pix(1'b1, 4'b0001, 4'b0001, 8'hff);
    vsync_cycle();
    void'(exp_q.pop_front());
    step();
    step();
    check("pre-reset score", 32'(bus.score), 32'h0001);
    #2 resetN = 1'b0;
    #1;
    check("async rst score",   32'(bus.score), 32'd0);
    check("async rst pulses",  32'({bus.t_kill, bus.ast_hit}), 32'd0);
    check("async rst overrun", 32'(bus.overrun), 32'd0);
    check("async rst state",   32'(bus.fsm_state), 32'd0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    model_clear();
    exp_q.delete();
    exp_score = 0;
    idle(NA + 2);
    check("post-reset score", 32'(bus.score), 32'd0);
    for (int p = 0; p < 3; p++) pix(1'b1, 4'b0001, 4'b0001, 8'h08);
    check_frame("post-reset single", 1'b1, 4'b0001, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
